// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared constants and helpers for the priority request encoder
package prio_enc_pkg;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;
  localparam int STATS_W  = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/prio_select.sv
// rtl/prio_select.sv - combinational wrap-around search: first eligible index at or below start_i
module prio_select
  import prio_enc_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = clog2(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [AW-1:0] start_i,
  output logic [AW-1:0] index_o,
  output logic          found_o
);

  // Scan start_i, start_i-1, ... wrapping through N-1; nearest hit wins.
  always_comb begin
    int pos;
    logic [AW-1:0] idx;
    index_o = '0;
    found_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start_i) - k;
      if (pos < 0) pos = pos + N;
      idx = AW'(pos);
      if (!found_o && eligible_i[idx]) begin
        found_o = 1'b1;
        index_o = idx;
      end
    end
  end

endmodule

// File: rtl/priority_req_encoder.sv
// rtl/priority_req_encoder.sv - pending-request encoder with fixed or round-robin issue
// Optional handshake counter output issue_cnt when PRIO_ENC_STATS_EN is defined.
module priority_req_encoder
  import prio_enc_pkg::*;
#(
  parameter int N       = 16,
  parameter int RR_MODE = RR_FIXED,
  localparam int AW     = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  output logic [AW-1:0] out_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  pending_o
`ifdef PRIO_ENC_STATS_EN
  ,
  output logic [STATS_W-1:0] issue_cnt
`endif
);

  logic [N-1:0]  pending_q, pending_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] grant_q, grant_d;
  logic          valid_q, valid_d;

  logic          stage_free;
  logic          found;
  logic [N-1:0]  eligible;
  logic [AW-1:0] rr_start;
  logic [AW-1:0] start;
  logic [AW-1:0] sel_idx;
  logic [N-1:0]  clr_mask;

  assign stage_free = !valid_q || out_ready;
  assign eligible   = pending_q & mask_i;
  // Round-robin searches from just below the last grant; grant 0 wraps to N-1.
  assign rr_start   = (grant_q == '0) ? AW'(N - 1) : grant_q - AW'(1);
  assign start      = (RR_MODE == RR_ROUND) ? rr_start : AW'(N - 1);

  prio_select #(
    .N  (N),
    .AW (AW)
  ) u_select (
    .eligible_i (eligible),
    .start_i    (start),
    .index_o    (sel_idx),
    .found_o    (found)
  );

  always_comb begin
    addr_d   = addr_q;
    valid_d  = valid_q;
    grant_d  = grant_q;
    clr_mask = '0;
    if (stage_free) begin
      valid_d = found;
      if (found) begin
        addr_d   = sel_idx;
        grant_d  = sel_idx;
        clr_mask = N'(1) << sel_idx;
      end
    end
    // A request arriving on the load edge re-arms the bit it clears.
    pending_d = (pending_q & ~clr_mask) | req_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      grant_q   <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
    end
  end

  assign out_addr  = addr_q;
  assign out_valid = valid_q;
  assign pending_o = pending_q;

`ifdef PRIO_ENC_STATS_EN
  logic [STATS_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (valid_q && out_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + STATS_W'(1);
    end
  end

  assign issue_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_priority_req_encoder.sv
// tb/tb_priority_req_encoder.sv - scoreboard bench for fixed and round-robin encoder instances
module tb_priority_req_encoder;

  logic        clk;
  logic        rst;
  logic [15:0] req_r;
  logic [15:0] mask_r;
  logic        ready_r;

  logic        dv [2];
  logic [3:0]  da [2];
  logic [15:0] dp [2];
`ifdef PRIO_ENC_STATS_EN
  logic [15:0] dc [2];
`endif

  int total;
  int bad;

  // Reference state, one slot per instance (0 = fixed, 1 = round-robin)
  logic [15:0] m_pend  [2];
  bit          m_valid [2];
  int          m_addr  [2];
  int          m_g     [2];
  logic [15:0] m_cnt   [2];
  int          exp_q   [2][$];
  int          hs_log  [2][$];
  int          exp_log [$];

  priority_req_encoder #(.N(16), .RR_MODE(0)) u_fix (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_r),
    .mask_i    (mask_r),
    .out_addr  (da[0]),
    .out_valid (dv[0]),
    .out_ready (ready_r),
    .pending_o (dp[0])
`ifdef PRIO_ENC_STATS_EN
    ,
    .issue_cnt (dc[0])
`endif
  );

  priority_req_encoder #(.N(16), .RR_MODE(1)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_r),
    .mask_i    (mask_r),
    .out_addr  (da[1]),
    .out_valid (dv[1]),
    .out_ready (ready_r),
    .pending_o (dp[1])
`ifdef PRIO_ENC_STATS_EN
    ,
    .issue_cnt (dc[1])
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s act=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic chk_log(input string nm, input int u, input bit exact);
    bit ok;
    int first_bad;
    ok = exact ? (hs_log[u].size() == exp_log.size()) : (hs_log[u].size() >= exp_log.size());
    first_bad = -1;
    if (ok) begin
      for (int i = 0; i < exp_log.size(); i++)
        if (first_bad < 0 && hs_log[u][i] != exp_log[i]) first_bad = i;
    end
    total++;
    if (!ok || first_bad >= 0) begin
      bad++;
      if (!ok)
        $display("FAIL %s count act=%0d want=%0d", nm, hs_log[u].size(), exp_log.size());
      else
        $display("FAIL %s item%0d act=%0d want=%0d", nm, first_bad, hs_log[u][first_bad], exp_log[first_bad]);
    end
  endtask

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      m_pend[u]  = '0;
      m_valid[u] = 1'b0;
      m_addr[u]  = 0;
      m_g[u]     = 0;
      m_cnt[u]   = '0;
      exp_q[u].delete();
    end
  endtask

  task automatic clear_logs();
    hs_log[0].delete();
    hs_log[1].delete();
    exp_log.delete();
  endtask

  // One edge of the behavioural model: handshake, selection by priority list, then request capture.
  task automatic model_step(input int u);
    logic [15:0] p;
    int pick;
    int cand;
    p = m_pend[u];
    pick = -1;
    if (m_valid[u] && ready_r && m_cnt[u] != 16'hFFFF) m_cnt[u] = m_cnt[u] + 16'd1;
    if (!m_valid[u] || ready_r) begin
      for (int d = 1; d <= 16; d++) begin
        cand = (u == 0) ? 16 - d : (m_g[u] - d + 16) % 16;
        if (pick < 0 && p[cand] && mask_r[cand]) pick = cand;
      end
      if (pick >= 0) begin
        p[pick]    = 1'b0;
        m_addr[u]  = pick;
        m_valid[u] = 1'b1;
        m_g[u]     = pick;
        exp_q[u].push_back(pick);
      end else begin
        m_valid[u] = 1'b0;
      end
    end
    m_pend[u] = p | req_r;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
  end

  // Monitor: checks state every cycle and scores each handshake against the expected queue.
  always @(negedge clk) begin
    int want_i;
    #2;
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("valid_u%0d", u), int'(dv[u]), int'(m_valid[u]));
        chk($sformatf("pending_u%0d", u), int'(dp[u]), int'(m_pend[u]));
        if (dv[u]) chk($sformatf("addr_u%0d", u), int'(da[u]), m_addr[u]);
`ifdef PRIO_ENC_STATS_EN
        chk($sformatf("issue_cnt_u%0d", u), int'(dc[u]), int'(m_cnt[u]));
`endif
        if (dv[u] && ready_r) begin
          if (exp_q[u].size() == 0) begin
            total++;
            bad++;
            $display("FAIL issue_u%0d act=%0d want=none", u, da[u]);
          end else begin
            want_i = exp_q[u].pop_front();
            chk($sformatf("issue_u%0d", u), int'(da[u]), want_i);
            hs_log[u].push_back(int'(da[u]));
          end
        end
      end
    end
  end

  task automatic cyc(input logic [15:0] r, input logic [15:0] m, input logic rd);
    @(negedge clk);
    #1;
    req_r   = r;
    mask_r  = m;
    ready_r = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #5;
    req_r   = '0;
    mask_r  = 16'hFFFF;
    ready_r = 1'b0;
    rst     = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_valid_u%0d", u), int'(dv[u]), 0);
      chk($sformatf("rst_addr_u%0d", u), int'(da[u]), 0);
      chk($sformatf("rst_pending_u%0d", u), int'(dp[u]), 0);
`ifdef PRIO_ENC_STATS_EN
      chk($sformatf("rst_issue_cnt_u%0d", u), int'(dc[u]), 0);
`endif
    end
    model_clear();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    req_r   = '0;
    mask_r  = 16'hFFFF;
    ready_r = 1'b0;
    model_clear();
    clear_logs();
    do_reset();

    // Fixed-priority drain of a single multi-bit pulse
    cyc(16'h8421, 16'hFFFF, 1'b1);
    repeat (6) cyc(16'h0000, 16'hFFFF, 1'b1);
    #3;
    exp_log = {15, 10, 5, 0};
    chk_log("drain_8421_fix", 0, 1'b1);
    chk_log("drain_8421_rr", 1, 1'b1);
    clear_logs();

    // Output held under backpressure while a higher request arrives
    cyc(16'h0008, 16'hFFFF, 1'b0);
    repeat (2) cyc(16'h0000, 16'hFFFF, 1'b0);
    cyc(16'h8000, 16'hFFFF, 1'b0);
    repeat (3) cyc(16'h0000, 16'hFFFF, 1'b0);
    #1;
    chk("hold_addr3", int'(da[0]), 3);
    chk("hold_valid", int'(dv[0]), 1);
    repeat (4) cyc(16'h0000, 16'hFFFF, 1'b1);
    #3;
    exp_log = {3, 15};
    chk_log("hold_then_15_fix", 0, 1'b1);
    chk_log("hold_then_15_rr", 1, 1'b1);

    // Round-robin rotation with every request held
    do_reset();
    clear_logs();
    repeat (20) cyc(16'hFFFF, 16'hFFFF, 1'b1);
    #3;
    for (int i = 15; i >= 0; i--) exp_log.push_back(i);
    exp_log.push_back(15);
    chk_log("rr_rotation", 1, 1'b0);
    exp_log = {15, 15, 15, 15, 15};
    chk_log("fix_starves_lower", 0, 1'b0);

    // Masked bits stay pending until their mask returns
    do_reset();
    clear_logs();
    cyc(16'h0F0F, 16'h00FF, 1'b1);
    repeat (6) cyc(16'h0000, 16'h00FF, 1'b1);
    #3;
    chk("masked_pending", int'(dp[0]), 16'h0F00);
    exp_log = {3, 2, 1, 0};
    chk_log("mask_low_fix", 0, 1'b1);
    chk_log("mask_low_rr", 1, 1'b1);
    clear_logs();
    repeat (6) cyc(16'h0000, 16'hFFFF, 1'b1);
    #3;
    exp_log = {11, 10, 9, 8};
    chk_log("mask_high_fix", 0, 1'b1);
    chk_log("mask_high_rr", 1, 1'b1);
    clear_logs();

    // Re-request on the load edge issues the same index again
    cyc(16'h0020, 16'hFFFF, 1'b1);
    cyc(16'h0020, 16'hFFFF, 1'b1);
    repeat (4) cyc(16'h0000, 16'hFFFF, 1'b1);
    #3;
    exp_log = {5, 5};
    chk_log("rereq_fix", 0, 1'b1);
    chk_log("rereq_rr", 1, 1'b1);

    // Reset while holding an output with more requests pending
    cyc(16'h01F0, 16'hFFFF, 1'b0);
    repeat (2) cyc(16'h0000, 16'hFFFF, 1'b0);
    #1;
    chk("pre_rst_pending", int'(dp[0]), 16'h00F0);
    chk("pre_rst_addr", int'(da[0]), 8);
    do_reset();
    cyc(16'h0002, 16'hFFFF, 1'b1);
    repeat (3) cyc(16'h0000, 16'hFFFF, 1'b1);

    // Randomized traffic with sparse requests, occasional masking and backpressure
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc(($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0000,
          ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'hFFFF,
          ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end
    repeat (40) cyc(16'h0000, 16'hFFFF, 1'b1);
    #3;
    chk("drain_q_fix", exp_q[0].size(), 0);
    chk("drain_q_rr", exp_q[1].size(), 0);
    chk("drain_idle_fix", int'(dv[0]), 0);
    chk("drain_idle_rr", int'(dv[1]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
